photo_capture_ctrl: RTL and testbench

PHOTO_CAPTURE_CTRL -- requirements
Module: photo_capture_ctrl

---
 rtl/photo_pkg.sv | 27 ++
 rtl/pixel_decimator.sv | 85 ++++++++
 rtl/photo_capture_ctrl.sv | 132 +++++++++++++
 tb/tb_photo_capture_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/photo_pkg.sv
// Shared types and constants for the photo capture controller.
package photo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_COUNTDOWN = 2'd1,
      ST_CAPTURE   = 2'd2,
      ST_DONE      = 2'd3
   } state_t;

   // Frame buffer geometry (2:1 decimated source)
   localparam int DST_W = 160;
   localparam int DST_H = 120;

   // RGB565 field positions; the top 4 bits of each channel are kept
   localparam int R_MSB = 15;
   localparam int R_LSB = 12;
   localparam int G_MSB = 10;
   localparam int G_LSB = 7;
   localparam int B_MSB = 4;
   localparam int B_LSB = 1;

   function automatic logic [11:0] rgb565_to_444(input logic [15:0] pix);
      return {pix[R_MSB:R_LSB], pix[G_MSB:G_LSB], pix[B_MSB:B_LSB]};
   endfunction

endpackage

// File: rtl/pixel_decimator.sv
// Raster position tracking, 2:1 decimation and frame buffer write generation.
module pixel_decimator
   import photo_pkg::*;
#(
   parameter int SRC_W = 320,
   parameter int SRC_H = 240
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_clear,
   input  logic        i_pix_valid,
   input  logic [15:0] i_pix_data,
   output logic        o_we,
   output logic [16:0] o_addr,
   output logic [11:0] o_data,
   output logic        o_last
);

   localparam int COL_W = $clog2(SRC_W);
   localparam int ROW_W = $clog2(SRC_H);

   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic             r_we;
   logic [16:0]      r_addr;
   logic [11:0]      r_data;

   logic             w_col_end;
   logic             w_row_end;
   logic             w_keep;
   logic             w_accept;
   logic [16:0]      w_addr;
   logic             w_unused_bits;

   assign w_col_end = (r_col == COL_W'(SRC_W - 1));
   assign w_row_end = (r_row == ROW_W'(SRC_H - 1));
   assign o_last    = w_col_end && w_row_end;

   // Even col/row only; the range guard keeps an oversized source from overrunning the buffer
   assign w_keep = !r_col[0] && !r_row[0] &&
                   ((32'(r_col) >> 1) < 32'(DST_W)) &&
                   ((32'(r_row) >> 1) < 32'(DST_H));

   // A clear (new frame) wins over a pixel presented in the same cycle
   assign w_accept = i_pix_valid && !i_clear;
   assign w_addr   = 17'(r_row >> 1) * 17'(DST_W) + 17'(r_col >> 1);

   // Bits dropped by the 565 -> 444 truncation
   assign w_unused_bits = ^{i_pix_data[11], i_pix_data[6], i_pix_data[0]};

   // Raster col/row counters, cleared at the start of every captured frame
   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_col <= '0;
         r_row <= '0;
      end else if (i_pix_valid) begin
         if (w_col_end) begin
            r_col <= '0;
            r_row <= w_row_end ? '0 : r_row + ROW_W'(1);
         end else begin
            r_col <= r_col + COL_W'(1);
         end
      end
   end

   // Registered write port: strobe one cycle after the accepted pixel
   always_ff @(posedge clk) begin
      if (reset) begin
         r_we   <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
      end else begin
         r_we <= w_accept && w_keep;
         if (w_accept && w_keep) begin
            r_addr <= w_addr;
            r_data <= rgb565_to_444(i_pix_data);
         end
      end
   end

   assign o_we   = r_we;
   assign o_addr = r_addr;
   assign o_data = r_data;

endmodule

// File: rtl/photo_capture_ctrl.sv
// Photo capture sequencer: shutter countdown, slot selection and frame capture.
//
//  state        | meaning
//  -------------+-----------------------------------------------------------
//  ST_IDLE      | waiting for the first shutter press after reset
//  ST_COUNTDOWN | counting frame_start pulses down to the captured frame
//  ST_CAPTURE   | writing the decimated frame into the current slot
//  ST_DONE      | all slots filled; shutter starts a new session at slot 0
module photo_capture_ctrl
   import photo_pkg::*;
#(
   parameter int SRC_W        = 320,
   parameter int SRC_H        = 240,
   parameter int COUNT_FRAMES = 90,
   parameter int NUM_SHOTS    = 4
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        shot_btn,
   input  logic        frame_start,
   input  logic        pix_valid,
   input  logic [15:0] pix_data,
   output logic        we,
   output logic [2:0]  num,
   output logic [16:0] wAddr,
   output logic [11:0] wData,
   output logic        busy,
   output logic        all_done,
   output logic [6:0]  frames_left
);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [6:0] r_frames_left;
   logic [6:0] w_frames_nxt;
   logic [2:0] r_num;
   logic [2:0] w_num_nxt;
   logic       w_clear;
   logic       w_pix_in;
   logic       w_at_last;

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state, countdown and slot decisions
   always_comb begin
      w_state_nxt  = r_state;
      w_frames_nxt = r_frames_left;
      w_num_nxt    = r_num;
      w_clear      = 1'b0;
      w_pix_in     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (shot_btn) begin
               w_state_nxt  = ST_COUNTDOWN;
               w_frames_nxt = 7'(COUNT_FRAMES);
               w_num_nxt    = '0;
            end
         end
         ST_COUNTDOWN: begin
            if (frame_start) begin
               if (r_frames_left == 7'd1) begin
                  w_state_nxt  = ST_CAPTURE;
                  w_frames_nxt = '0;
                  w_clear      = 1'b1;
               end else begin
                  w_frames_nxt = r_frames_left - 7'd1;
               end
            end
         end
         ST_CAPTURE: begin
            w_pix_in = pix_valid;
            if (frame_start) begin
               w_clear = 1'b1;
            end else if (pix_valid && w_at_last) begin
               // The last pixel sits on an odd column, so no write to the
               // old slot is still pending when num moves on.
               if (r_num == 3'(NUM_SHOTS - 1)) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_state_nxt  = ST_COUNTDOWN;
                  w_num_nxt    = r_num + 3'd1;
                  w_frames_nxt = 7'(COUNT_FRAMES);
               end
            end
         end
         ST_DONE: begin
            if (shot_btn) begin
               w_state_nxt  = ST_COUNTDOWN;
               w_frames_nxt = 7'(COUNT_FRAMES);
               w_num_nxt    = '0;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Countdown and slot registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_frames_left <= '0;
         r_num         <= '0;
      end else begin
         r_frames_left <= w_frames_nxt;
         r_num         <= w_num_nxt;
      end
   end

   pixel_decimator #(
      .SRC_W (SRC_W),
      .SRC_H (SRC_H)
   ) u_decim (
      .clk         (clk),
      .reset       (reset),
      .i_clear     (w_clear),
      .i_pix_valid (w_pix_in),
      .i_pix_data  (pix_data),
      .o_we        (we),
      .o_addr      (wAddr),
      .o_data      (wData),
      .o_last      (w_at_last)
   );

   assign num         = r_num;
   assign frames_left = r_frames_left;
   assign busy        = (r_state == ST_COUNTDOWN) || (r_state == ST_CAPTURE);
   assign all_done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_photo_capture_ctrl.sv
// Self-checking bench for photo_capture_ctrl with a reduced source frame.
module tb_photo_capture_ctrl;

   localparam int SRC_W = 64;
   localparam int SRC_H = 32;
   localparam int CF    = 52;
   localparam int NS    = 4;
   localparam int NPIX  = SRC_W * SRC_H;

   logic        clk = 1'b0;
   logic        reset;
   logic        shot_btn;
   logic        frame_start;
   logic        pix_valid;
   logic [15:0] pix_data;
   logic        we;
   logic [2:0]  num;
   logic [16:0] wAddr;
   logic [11:0] wData;
   logic        busy;
   logic        all_done;
   logic [6:0]  frames_left;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      int slot;
      int addr;
      int data;
   } wr_t;

   wr_t         obs_q[$];
   wr_t         exp_q[$];
   logic [15:0] sent_q[$];

   always #5 clk = ~clk;

   photo_capture_ctrl #(
      .SRC_W        (SRC_W),
      .SRC_H        (SRC_H),
      .COUNT_FRAMES (CF),
      .NUM_SHOTS    (NS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .shot_btn    (shot_btn),
      .frame_start (frame_start),
      .pix_valid   (pix_valid),
      .pix_data    (pix_data),
      .we          (we),
      .num         (num),
      .wAddr       (wAddr),
      .wData       (wData),
      .busy        (busy),
      .all_done    (all_done),
      .frames_left (frames_left)
   );

   // Record every frame buffer write
   always @(negedge clk) begin
      if (we === 1'b1)
         obs_q.push_back('{slot: int'(num), addr: int'(wAddr), data: int'(wData)});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      shot_btn    = 1'b0;
      frame_start = 1'b0;
      pix_valid   = 1'b0;
      pix_data    = '0;
   endtask

   task automatic pulse_fs();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic press_btn();
      shot_btn = 1'b1;
      tick();
      shot_btn = 1'b0;
   endtask

   task automatic countdown(input int n);
      repeat (n) begin
         pulse_fs();
         repeat ($urandom_range(0, 2)) tick();
      end
   endtask

   task automatic drive_pixels(input int n);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) tick();
         pix_valid = 1'b1;
         pix_data  = 16'($urandom);
         sent_q.push_back(pix_data);
         tick();
         pix_valid = 1'b0;
      end
   endtask

   // Reference: every even-row, even-column pixel of the frame lands at its
   // halved coordinates in a 160-wide buffer, keeping the top nibble per channel.
   task automatic model_frame(input int slot);
      for (int k = 0; k < sent_q.size(); k++) begin
         int row, col, p;
         row = k / SRC_W;
         col = k % SRC_W;
         p   = int'(sent_q[k]);
         if (row % 2 == 0 && col % 2 == 0)
            exp_q.push_back('{slot: slot, addr: (row / 2) * 160 + col / 2,
                              data: (((p >> 12) & 15) << 8) | (((p >> 7) & 15) << 4) | ((p >> 1) & 15)});
      end
      sent_q.delete();
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      repeat (3) tick();
      n_cmp++; if (we !== 1'b0)          begin n_err++; $display("FAIL reset_we: got %b want 0", we); end
      n_cmp++; if (num !== 3'd0)         begin n_err++; $display("FAIL reset_num: got %0d want 0", num); end
      n_cmp++; if (wAddr !== 17'd0)      begin n_err++; $display("FAIL reset_waddr: got %0d want 0", wAddr); end
      n_cmp++; if (wData !== 12'd0)      begin n_err++; $display("FAIL reset_wdata: got %h want 0", wData); end
      n_cmp++; if (busy !== 1'b0)        begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (all_done !== 1'b0)    begin n_err++; $display("FAIL reset_all_done: got %b want 0", all_done); end
      n_cmp++; if (frames_left !== 7'd0) begin n_err++; $display("FAIL reset_frames_left: got %0d want 0", frames_left); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_countdown();
      press_btn();
      n_cmp++; if (busy !== 1'b1)       begin n_err++; $display("FAIL cd_busy: got %b want 1", busy); end
      n_cmp++; if (frames_left !== 7'(CF)) begin n_err++; $display("FAIL cd_start: got %0d want %0d", frames_left, CF); end
      n_cmp++; if (num !== 3'd0)        begin n_err++; $display("FAIL cd_num: got %0d want 0", num); end
      countdown(CF - 50);
      n_cmp++; if (frames_left !== 7'd50) begin n_err++; $display("FAIL cd_50: got %0d want 50", frames_left); end
      press_btn();
      n_cmp++; if (frames_left !== 7'd50) begin n_err++; $display("FAIL cd_btn_ignored: got %0d want 50", frames_left); end
      n_cmp++; if (busy !== 1'b1 || all_done !== 1'b0) begin n_err++; $display("FAIL cd_btn_state: got busy %b done %b want 1 0", busy, all_done); end
      obs_q.delete();
      pix_valid = 1'b1;
      repeat (10) begin pix_data = 16'($urandom); tick(); end
      pix_valid = 1'b0;
      tick();
      n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL cd_pix_no_write: got %0d writes want 0", obs_q.size()); end
      countdown(49);
      n_cmp++; if (frames_left !== 7'd1) begin n_err++; $display("FAIL cd_one: got %0d want 1", frames_left); end
      pulse_fs();
      n_cmp++; if (frames_left !== 7'd0 || busy !== 1'b1) begin n_err++; $display("FAIL cd_enter_capture: got fl %0d busy %b want 0 1", frames_left, busy); end
   endtask

   task automatic test_first_shot();
      obs_q.delete();
      exp_q.delete();
      sent_q.delete();
      pix_valid = 1'b1;
      pix_data  = 16'hF81F;
      sent_q.push_back(pix_data);
      tick();
      n_cmp++; if (we !== 1'b1 || wAddr !== 17'd0 || wData !== 12'hF0F)
         begin n_err++; $display("FAIL first_pixel: got we %b addr %0d data %h want 1 0 f0f", we, wAddr, wData); end
      pix_data = 16'($urandom);
      sent_q.push_back(pix_data);
      tick();
      pix_valid = 1'b0;
      n_cmp++; if (we !== 1'b0) begin n_err++; $display("FAIL col1_no_write: got %b want 0", we); end
      drive_pixels(NPIX - 2);
      tick();
      model_frame(0);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL shot0_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i].slot != exp_q[i].slot || obs_q[i].addr != exp_q[i].addr || obs_q[i].data != exp_q[i].data) begin
            n_err++;
            $display("FAIL shot0_wr[%0d]: got slot %0d addr %0d data %h want slot %0d addr %0d data %h",
                     i, obs_q[i].slot, obs_q[i].addr, obs_q[i].data, exp_q[i].slot, exp_q[i].addr, exp_q[i].data);
         end
      end
      if (obs_q.size() > 0) begin
         n_cmp++; if (obs_q[obs_q.size()-1].addr != (SRC_H / 2 - 1) * 160 + SRC_W / 2 - 1)
            begin n_err++; $display("FAIL shot0_last_addr: got %0d want %0d", obs_q[obs_q.size()-1].addr, (SRC_H / 2 - 1) * 160 + SRC_W / 2 - 1); end
      end
      n_cmp++; if (num !== 3'd1 || busy !== 1'b1 || frames_left !== 7'(CF))
         begin n_err++; $display("FAIL shot0_next: got num %0d busy %b fl %0d want 1 1 %0d", num, busy, frames_left, CF); end
   endtask

   task automatic test_restart();
      int n_partial;
      countdown(CF);
      obs_q.delete();
      exp_q.delete();
      sent_q.delete();
      drive_pixels(500);
      press_btn();
      drive_pixels(500);
      n_cmp++; if (frames_left !== 7'd0 || busy !== 1'b1 || num !== 3'd1)
         begin n_err++; $display("FAIL restart_btn_ignored: got fl %0d busy %b num %0d want 0 1 1", frames_left, busy, num); end
      model_frame(1);
      n_partial = exp_q.size();
      pulse_fs();
      n_cmp++; if (num !== 3'd1) begin n_err++; $display("FAIL restart_num: got %0d want 1", num); end
      drive_pixels(NPIX);
      tick();
      model_frame(1);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL restart_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i].slot != exp_q[i].slot || obs_q[i].addr != exp_q[i].addr || obs_q[i].data != exp_q[i].data) begin
            n_err++;
            $display("FAIL restart_wr[%0d]: got slot %0d addr %0d data %h want slot %0d addr %0d data %h",
                     i, obs_q[i].slot, obs_q[i].addr, obs_q[i].data, exp_q[i].slot, exp_q[i].addr, exp_q[i].data);
         end
      end
      if (obs_q.size() > n_partial) begin
         n_cmp++; if (obs_q[n_partial].addr != 0) begin n_err++; $display("FAIL restart_first_addr: got %0d want 0", obs_q[n_partial].addr); end
      end
      n_cmp++; if (num !== 3'd2) begin n_err++; $display("FAIL restart_next_num: got %0d want 2", num); end
   endtask

   task automatic test_done();
      for (int shot = 2; shot < NS; shot++) begin
         countdown(CF);
         obs_q.delete();
         exp_q.delete();
         sent_q.delete();
         drive_pixels(NPIX);
         tick();
         model_frame(shot);
         n_cmp++;
         if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL shot%0d_count: got %0d want %0d", shot, obs_q.size(), exp_q.size()); end
         for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].slot != exp_q[i].slot || obs_q[i].addr != exp_q[i].addr || obs_q[i].data != exp_q[i].data) begin
               n_err++;
               $display("FAIL shot%0d_wr[%0d]: got slot %0d addr %0d data %h want slot %0d addr %0d data %h",
                        shot, i, obs_q[i].slot, obs_q[i].addr, obs_q[i].data, exp_q[i].slot, exp_q[i].addr, exp_q[i].data);
            end
         end
      end
      n_cmp++; if (all_done !== 1'b1 || num !== 3'(NS - 1) || busy !== 1'b0 || frames_left !== 7'd0)
         begin n_err++; $display("FAIL done_state: got done %b num %0d busy %b fl %0d want 1 %0d 0 0", all_done, num, busy, frames_left, NS - 1); end
      obs_q.delete();
      pulse_fs();
      drive_pixels(NPIX);
      sent_q.delete();
      tick();
      n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL done_no_write: got %0d writes want 0", obs_q.size()); end
      n_cmp++; if (all_done !== 1'b1) begin n_err++; $display("FAIL done_hold: got %b want 1", all_done); end
      press_btn();
      n_cmp++; if (num !== 3'd0 || busy !== 1'b1 || all_done !== 1'b0 || frames_left !== 7'(CF))
         begin n_err++; $display("FAIL done_restart: got num %0d busy %b done %b fl %0d want 0 1 0 %0d", num, busy, all_done, frames_left, CF); end
   endtask

   task automatic test_reset_mid_capture();
      countdown(CF);
      obs_q.delete();
      pix_valid = 1'b1;
      pix_data  = 16'hFFFF;
      reset     = 1'b1;
      tick();
      reset     = 1'b0;
      pix_valid = 1'b0;
      n_cmp++; if (we !== 1'b0)       begin n_err++; $display("FAIL rst_cap_we: got %b want 0", we); end
      n_cmp++; if (num !== 3'd0 || wAddr !== 17'd0 || wData !== 12'd0)
         begin n_err++; $display("FAIL rst_cap_port: got num %0d addr %0d data %h want 0 0 0", num, wAddr, wData); end
      n_cmp++; if (busy !== 1'b0 || all_done !== 1'b0 || frames_left !== 7'd0)
         begin n_err++; $display("FAIL rst_cap_status: got busy %b done %b fl %0d want 0 0 0", busy, all_done, frames_left); end
      tick();
      n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL rst_cap_no_write: got %0d writes want 0", obs_q.size()); end
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      test_reset();
      test_countdown();
      test_first_shot();
      test_restart();
      test_done();
      test_reset_mid_capture();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
